// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the IF and LS requesters
//
// Purpose: single-outstanding memory port arbiter. LS wins over IF unless IF
// has lost STARVE_LIMIT arbitrations in a row, in which case IF wins the next one.
// Each response is routed back to the requester that owns the transaction.
//
// Parameters:
//   STARVE_LIMIT  consecutive IF losses before IF is forced to win (0 = pure LS priority, 0..15)
//
// Optional build macro:
//   MEM_ARB_RESP_REG_EN  registers the response path (extra RESP state, +1 cycle latency)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req_valid/ready/addr        IF read request channel
//   if_resp_valid/rdata            IF read data (1-cycle pulse)
//   ls_req_valid/ready/wen/addr/wdata/wlen   LS request channel
//   ls_resp_valid/rdata            LS load data / store ack (rdata 0 for stores)
//   mem_req_valid/ready/wen/addr/wdata/wlen  downstream request channel
//   mem_resp_valid/rdata           downstream response

module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_rdata,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_wen,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    input  logic [2:0]  ls_req_wlen,
    output logic        ls_resp_valid,
    output logic [31:0] ls_resp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [2:0]  mem_req_wlen,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        owner_ls_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  wlen_q;
    logic [3:0]  starve_q;

    logic        idle;
    logic        force_if;
    logic        ls_win;
    logic        if_win;
    logic        accept;

    assign idle     = (state_q == S_IDLE);
    // The guard only overrides LS when IF is actually asking.
    assign force_if = (LIMIT != 4'd0) && (starve_q == LIMIT) && if_req_valid;
    assign ls_win   = ls_req_valid && !force_if;
    assign if_win   = if_req_valid && !ls_win;
    assign accept   = idle && (ls_win || if_win);

`ifdef MEM_ARB_RESP_REG_EN
    logic [31:0] resp_data_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ls_win || if_win) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
`ifdef MEM_ARB_RESP_REG_EN
                    state_d = S_RESP;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; everything is held at 0 while rst is asserted.
    always_comb begin
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        if_resp_rdata = 32'd0;
        ls_resp_valid = 1'b0;
        ls_resp_rdata = 32'd0;
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_wdata = 32'd0;
        mem_req_wlen  = 3'd0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if_req_ready = if_win;
                    ls_req_ready = ls_win;
                end
                S_ISSUE: begin
                    mem_req_valid = 1'b1;
                    mem_req_wen   = wen_q;
                    mem_req_addr  = addr_q;
                    mem_req_wdata = wdata_q;
                    mem_req_wlen  = wlen_q;
                end
`ifdef MEM_ARB_RESP_REG_EN
                S_RESP: begin
                    if (owner_ls_q) begin
                        ls_resp_valid = 1'b1;
                        ls_resp_rdata = resp_data_q;
                    end else begin
                        if_resp_valid = 1'b1;
                        if_resp_rdata = resp_data_q;
                    end
                end
`else
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (owner_ls_q) begin
                            ls_resp_valid = 1'b1;
                            ls_resp_rdata = wen_q ? 32'd0 : mem_resp_rdata;
                        end else begin
                            if_resp_valid = 1'b1;
                            if_resp_rdata = mem_resp_rdata;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Transaction latch and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_ls_q <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wlen_q     <= 3'd0;
            starve_q   <= 4'd0;
        end else begin
            if (accept) begin
                owner_ls_q <= ls_win;
                if (ls_win) begin
                    wen_q   <= ls_req_wen;
                    addr_q  <= ls_req_addr;
                    wdata_q <= ls_req_wdata;
                    wlen_q  <= ls_req_wlen;
                end else begin
                    wen_q   <= 1'b0;
                    addr_q  <= if_req_addr;
                    wdata_q <= 32'd0;
                    wlen_q  <= 3'd0;
                end
            end
            if (idle) begin
                if (!if_req_valid || if_win) begin
                    starve_q <= 4'd0;
                end else if (ls_win && (starve_q != LIMIT)) begin
                    starve_q <= starve_q + 4'd1;
                end
            end
        end
    end

`ifdef MEM_ARB_RESP_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= 32'd0;
        end else if ((state_q == S_WAIT) && mem_resp_valid) begin
            resp_data_q <= (owner_ls_q && wen_q) ? 32'd0 : mem_resp_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT inputs (shared by both instances)
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = 32'd0;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_wen = 1'b0;
    logic [31:0] ls_req_addr = 32'd0;
    logic [31:0] ls_req_wdata = 32'd0;
    logic [2:0]  ls_req_wlen = 3'd0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = 32'd0;

    // Next-cycle stimulus, applied at the falling edge
    logic        n_rst = 1'b1;
    logic        n_ifv = 1'b0;
    logic [31:0] n_ifa = 32'd0;
    logic        n_lsv = 1'b0;
    logic        n_lsw = 1'b0;
    logic [31:0] n_lsa = 32'd0;
    logic [31:0] n_lsd = 32'd0;
    logic [2:0]  n_lsl = 3'd0;
    logic        n_mrr = 1'b0;
    logic        n_mrv = 1'b0;
    logic [31:0] n_mrd = 32'd0;

    // DUT outputs: index 0 has STARVE_LIMIT=4, index 1 has STARVE_LIMIT=0
    logic        o_if_req_ready  [2];
    logic        o_if_resp_valid [2];
    logic [31:0] o_if_resp_rdata [2];
    logic        o_ls_req_ready  [2];
    logic        o_ls_resp_valid [2];
    logic [31:0] o_ls_resp_rdata [2];
    logic        o_mem_req_valid [2];
    logic        o_mem_req_wen   [2];
    logic [31:0] o_mem_req_addr  [2];
    logic [31:0] o_mem_req_wdata [2];
    logic [2:0]  o_mem_req_wlen  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.STARVE_LIMIT((g == 0) ? 4 : 0)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .if_req_valid   (if_req_valid),
            .if_req_ready   (o_if_req_ready[g]),
            .if_req_addr    (if_req_addr),
            .if_resp_valid  (o_if_resp_valid[g]),
            .if_resp_rdata  (o_if_resp_rdata[g]),
            .ls_req_valid   (ls_req_valid),
            .ls_req_ready   (o_ls_req_ready[g]),
            .ls_req_wen     (ls_req_wen),
            .ls_req_addr    (ls_req_addr),
            .ls_req_wdata   (ls_req_wdata),
            .ls_req_wlen    (ls_req_wlen),
            .ls_resp_valid  (o_ls_resp_valid[g]),
            .ls_resp_rdata  (o_ls_resp_rdata[g]),
            .mem_req_valid  (o_mem_req_valid[g]),
            .mem_req_ready  (mem_req_ready),
            .mem_req_wen    (o_mem_req_wen[g]),
            .mem_req_addr   (o_mem_req_addr[g]),
            .mem_req_wdata  (o_mem_req_wdata[g]),
            .mem_req_wlen   (o_mem_req_wlen[g]),
            .mem_resp_valid (mem_resp_valid),
            .mem_resp_rdata (mem_resp_rdata)
        );
    end

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model: at most one transaction, tracked as
    // "in flight" and "accepted downstream", plus an optional pending response.
    int          lim      [2];
    bit          m_busy   [2];
    bit          m_acked  [2];
    bit          m_ls     [2];
    bit          m_wen    [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [2:0]  m_wlen   [2];
    int          m_starve [2];
    bit          m_pend   [2];
    logic [31:0] m_pdata  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_acked[k] = 0; m_ls[k] = 0; m_wen[k] = 0;
            m_addr[k] = 0; m_wdata[k] = 0; m_wlen[k] = 0;
            m_starve[k] = 0; m_pend[k] = 0; m_pdata[k] = 0;
        end
    endtask

    // One cycle: apply stimulus, check every output against the model, advance the model.
    task automatic step();
        @(negedge clk);
        rst = n_rst; if_req_valid = n_ifv; if_req_addr = n_ifa;
        ls_req_valid = n_lsv; ls_req_wen = n_lsw; ls_req_addr = n_lsa;
        ls_req_wdata = n_lsd; ls_req_wlen = n_lsl;
        mem_req_ready = n_mrr; mem_resp_valid = n_mrv; mem_resp_rdata = n_mrd;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit idle, frc, lsw, ifw, fire, ack;
            logic        e_ifr, e_lsr, e_ifv, e_lsv, e_mv, e_mw;
            logic [31:0] e_ifd, e_lsd, e_ma, e_md, rd;
            logic [2:0]  e_ml;
            e_ifr = 0; e_lsr = 0; e_ifv = 0; e_lsv = 0; e_mv = 0; e_mw = 0;
            e_ifd = 0; e_lsd = 0; e_ma = 0; e_md = 0; e_ml = 0;
            idle = !m_busy[k] && !m_pend[k];
            frc  = (lim[k] != 0) && (m_starve[k] == lim[k]) && if_req_valid;
            lsw  = idle && ls_req_valid && !frc;
            ifw  = idle && if_req_valid && !lsw;
            fire = m_busy[k] && m_acked[k] && mem_resp_valid;
            ack  = m_busy[k] && !m_acked[k] && mem_req_ready;
            rd   = (m_ls[k] && m_wen[k]) ? 32'd0 : mem_resp_rdata;
            if (!rst) begin
                e_ifr = ifw; e_lsr = lsw;
                if (m_busy[k] && !m_acked[k]) begin
                    e_mv = 1; e_mw = m_wen[k]; e_ma = m_addr[k];
                    e_md = m_wdata[k]; e_ml = m_wlen[k];
                end
`ifdef MEM_ARB_RESP_REG_EN
                if (m_pend[k]) begin
                    if (m_ls[k]) begin e_lsv = 1; e_lsd = m_pdata[k]; end
                    else begin e_ifv = 1; e_ifd = m_pdata[k]; end
                end
`else
                if (fire) begin
                    if (m_ls[k]) begin e_lsv = 1; e_lsd = rd; end
                    else begin e_ifv = 1; e_ifd = rd; end
                end
`endif
            end
            chk($sformatf("u%0d.if_req_ready", k),  32'(o_if_req_ready[k]),  32'(e_ifr));
            chk($sformatf("u%0d.ls_req_ready", k),  32'(o_ls_req_ready[k]),  32'(e_lsr));
            chk($sformatf("u%0d.if_resp_valid", k), 32'(o_if_resp_valid[k]), 32'(e_ifv));
            chk($sformatf("u%0d.if_resp_rdata", k), o_if_resp_rdata[k], e_ifd);
            chk($sformatf("u%0d.ls_resp_valid", k), 32'(o_ls_resp_valid[k]), 32'(e_lsv));
            chk($sformatf("u%0d.ls_resp_rdata", k), o_ls_resp_rdata[k], e_lsd);
            chk($sformatf("u%0d.mem_req_valid", k), 32'(o_mem_req_valid[k]), 32'(e_mv));
            chk($sformatf("u%0d.mem_req_wen", k),   32'(o_mem_req_wen[k]),   32'(e_mw));
            chk($sformatf("u%0d.mem_req_addr", k),  o_mem_req_addr[k], e_ma);
            chk($sformatf("u%0d.mem_req_wdata", k), o_mem_req_wdata[k], e_md);
            chk($sformatf("u%0d.mem_req_wlen", k),  32'(o_mem_req_wlen[k]),  32'(e_ml));
            if (rst) begin
                m_busy[k] = 0; m_acked[k] = 0; m_ls[k] = 0; m_wen[k] = 0;
                m_addr[k] = 0; m_wdata[k] = 0; m_wlen[k] = 0;
                m_starve[k] = 0; m_pend[k] = 0; m_pdata[k] = 0;
            end else begin
                if (m_pend[k]) m_pend[k] = 0;
                if (fire) begin
                    m_busy[k] = 0;
`ifdef MEM_ARB_RESP_REG_EN
                    m_pend[k] = 1; m_pdata[k] = rd;
`endif
                end
                if (ack) m_acked[k] = 1;
                if (idle) begin
                    if (!if_req_valid || ifw) m_starve[k] = 0;
                    else if (lsw) m_starve[k] = (m_starve[k] + 1 > lim[k]) ? lim[k] : m_starve[k] + 1;
                    if (lsw || ifw) begin
                        m_busy[k] = 1; m_acked[k] = 0; m_ls[k] = lsw;
                        m_wen[k]   = lsw ? ls_req_wen : 1'b0;
                        m_addr[k]  = lsw ? ls_req_addr : if_req_addr;
                        m_wdata[k] = lsw ? ls_req_wdata : 32'd0;
                        m_wlen[k]  = lsw ? ls_req_wlen : 3'd0;
                    end
                end
            end
        end
    endtask

    // Drive the downstream side until instance 0 returns a response (bounded).
    task automatic run_txn(input logic [31:0] rdv, output logic g_if, output logic g_ls,
                           output logic [31:0] d_if, output logic [31:0] d_ls);
        g_if = 0; g_ls = 0; d_if = 0; d_ls = 0;
        n_mrr = 1; n_mrv = 1; n_mrd = rdv;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_if_resp_valid[0] || o_ls_resp_valid[0]) begin
                g_if = o_if_resp_valid[0]; g_ls = o_ls_resp_valid[0];
                d_if = o_if_resp_rdata[0]; d_ls = o_ls_resp_rdata[0];
                break;
            end
        end
        n_mrr = 0; n_mrv = 0; n_mrd = 0;
    endtask

    logic        g_if, g_ls;
    logic [31:0] d_if, d_ls;
    logic [9:0]  order0, order1;
    int          cnt0, cnt1;

    initial begin
        lim[0] = 4; lim[1] = 0;
        model_reset();
        step(); step();
        n_rst = 0;
        step();
        chk("reset.mem_req_valid", 32'(o_mem_req_valid[0]), 32'd0);
        chk("reset.if_req_ready", 32'(o_if_req_ready[0]), 32'd0);

        // 1: IF only
        n_ifv = 1; n_ifa = 32'h8000_0000;
        step();
        chk("t1.if_req_ready", 32'(o_if_req_ready[0]), 32'd1);
        n_ifv = 0; n_mrr = 1;
        step();
        chk("t1.mem_req_valid", 32'(o_mem_req_valid[0]), 32'd1);
        chk("t1.mem_req_addr", o_mem_req_addr[0], 32'h8000_0000);
        chk("t1.mem_req_wen", 32'(o_mem_req_wen[0]), 32'd0);
        run_txn(32'h0000_0413, g_if, g_ls, d_if, d_ls);
        chk("t1.if_resp_valid", 32'(g_if), 32'd1);
        chk("t1.if_resp_rdata", d_if, 32'h0000_0413);
        chk("t1.ls_resp_valid", 32'(g_ls), 32'd0);

        // 2: IF and LS together, LS first, IF right after
        n_ifv = 1; n_ifa = 32'h8000_0004;
        n_lsv = 1; n_lsw = 0; n_lsa = 32'h8000_1000;
        step();
        chk("t2.ls_req_ready", 32'(o_ls_req_ready[0]), 32'd1);
        chk("t2.if_req_ready", 32'(o_if_req_ready[0]), 32'd0);
        n_lsv = 0;
        run_txn(32'hCAFE_F00D, g_if, g_ls, d_if, d_ls);
        chk("t2.ls_resp_valid", 32'(g_ls), 32'd1);
        chk("t2.ls_resp_rdata", d_ls, 32'hCAFE_F00D);
        step();
        chk("t2.if_req_ready_after", 32'(o_if_req_ready[0]), 32'd1);
        n_ifv = 0;
        run_txn(32'h0000_0011, g_if, g_ls, d_if, d_ls);
        chk("t2.if_resp_rdata", d_if, 32'h0000_0011);

        // 3: store with downstream stall
        n_lsv = 1; n_lsw = 1; n_lsa = 32'h8000_2000; n_lsd = 32'hDEAD_BEEF; n_lsl = 3'd4;
        step();
        chk("t3.ls_req_ready", 32'(o_ls_req_ready[0]), 32'd1);
        n_lsv = 0; n_lsw = 0; n_lsd = 0; n_lsl = 0;
        for (int i = 0; i < 4; i++) begin
            n_mrr = (i == 3);
            step();
            chk($sformatf("t3.mem_req_valid[%0d]", i), 32'(o_mem_req_valid[0]), 32'd1);
            chk($sformatf("t3.mem_req_wdata[%0d]", i), o_mem_req_wdata[0], 32'hDEAD_BEEF);
            chk($sformatf("t3.mem_req_wlen[%0d]", i), 32'(o_mem_req_wlen[0]), 32'd4);
            chk($sformatf("t3.mem_req_addr[%0d]", i), o_mem_req_addr[0], 32'h8000_2000);
        end
        run_txn(32'h1234_5678, g_if, g_ls, d_if, d_ls);
        chk("t3.ls_resp_valid", 32'(g_ls), 32'd1);
        chk("t3.ls_resp_rdata", d_ls, 32'd0);

        // 4: starvation guard grant order
        step();
        n_ifv = 1; n_lsv = 1; n_lsa = 32'h8000_1004; n_mrr = 1; n_mrv = 1; n_mrd = 32'h55;
        order0 = 0; order1 = 0; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 80 && (cnt0 < 10 || cnt1 < 10); i++) begin
            step();
            if (cnt0 < 10 && (o_if_req_ready[0] || o_ls_req_ready[0])) begin
                order0[cnt0] = o_if_req_ready[0]; cnt0++;
            end
            if (cnt1 < 10 && (o_if_req_ready[1] || o_ls_req_ready[1])) begin
                order1[cnt1] = o_if_req_ready[1]; cnt1++;
            end
        end
        chk("t4.order_limit4", 32'(order0), 32'h210);
        chk("t4.grants_limit4", 32'(cnt0), 32'd10);
        chk("t4.order_limit0", 32'(order1), 32'h000);
        n_ifv = 0; n_lsv = 0;
        for (int i = 0; i < 5; i++) step();
        n_mrr = 0; n_mrv = 0;

        // 5: reset while waiting for a response
        n_ifv = 1; n_ifa = 32'h8000_0040;
        step();
        chk("t5.if_req_ready", 32'(o_if_req_ready[0]), 32'd1);
        n_ifv = 0; n_mrr = 1;
        step();
        n_mrr = 0; n_rst = 1; n_mrv = 1; n_mrd = 32'hBAD0_BAD0;
        step();
        chk("t5.no_resp_in_rst", 32'(o_if_resp_valid[0]), 32'd0);
        n_rst = 0;
        step();
        chk("t5.if_resp_after_rst", 32'(o_if_resp_valid[0]), 32'd0);
        chk("t5.mem_req_valid_after_rst", 32'(o_mem_req_valid[0]), 32'd0);
        n_mrv = 0; n_ifv = 1; n_ifa = 32'h8000_0044;
        step();
        chk("t5.next_if_ready", 32'(o_if_req_ready[0]), 32'd1);
        n_ifv = 0;
        run_txn(32'h0000_0013, g_if, g_ls, d_if, d_ls);
        chk("t5.next_if_rdata", d_if, 32'h0000_0013);

        // 6: spurious responses in IDLE and ISSUE
        n_mrv = 1; n_mrd = 32'h7777_7777;
        step();
        chk("t6.idle_no_resp", 32'(o_if_resp_valid[0] | o_ls_resp_valid[0]), 32'd0);
        n_lsv = 1; n_lsa = 32'h8000_3000;
        step();
        n_lsv = 0; n_mrr = 0;
        step();
        chk("t6.issue_no_resp", 32'(o_if_resp_valid[0] | o_ls_resp_valid[0]), 32'd0);
        step();
        chk("t6.issue_held", 32'(o_mem_req_valid[0]), 32'd1);
        run_txn(32'h0BAD_CAFE, g_if, g_ls, d_if, d_ls);
        chk("t6.ls_rdata", d_ls, 32'h0BAD_CAFE);

        // Randomized traffic, varying request density per segment
        for (int s = 0; s < 6; s++) begin
            int p_if, p_ls;
            p_if = int'($urandom_range(20, 100));
            p_ls = int'($urandom_range(20, 100));
            for (int i = 0; i < 500; i++) begin
                n_rst = ($urandom_range(0, 255) == 0);
                n_ifv = (int'($urandom_range(0, 99)) < p_if);
                n_ifa = $urandom;
                n_lsv = (int'($urandom_range(0, 99)) < p_ls);
                n_lsw = 1'($urandom);
                n_lsa = $urandom;
                n_lsd = $urandom;
                n_lsl = 3'($urandom);
                n_mrr = 1'($urandom);
                n_mrv = ($urandom_range(0, 9) < 4);
                n_mrd = $urandom;
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one memory port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read or write) of the single-cycle core. It holds at most one outstanding transaction, uses fixed LS-over-IF priority with an IF starvation guard, and routes each response back to the requester that owns the transaction.

Parameters:
STARVE_LIMIT, 4, number of consecutive IF losses after which IF wins the next arbitration; 0 disables the guard (pure LS priority); legal range 0..15.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req_valid  in  1  IF read request valid
if_req_ready  out  1  IF request accepted this cycle
if_req_addr  in  32  IF read address
if_resp_valid  out  1  IF read data valid (1-cycle pulse)
if_resp_rdata  out  32  IF read data
ls_req_valid  in  1  LS request valid
ls_req_ready  out  1  LS request accepted this cycle
ls_req_wen  in  1  1 = store, 0 = load
ls_req_addr  in  32  LS address
ls_req_wdata  in  32  store data
ls_req_wlen  in  3  store length code, passed through unchanged
ls_resp_valid  out  1  load data valid / store acknowledge (1-cycle pulse)
ls_resp_rdata  out  32  load data; 0 for stores
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream accepts request
mem_req_wen  out  1  downstream write enable
mem_req_addr  out  32  downstream address
mem_req_wdata  out  32  downstream write data
mem_req_wlen  out  3  downstream store length
mem_resp_valid  in  1  downstream read data valid / write ack
mem_resp_rdata  in  32  downstream read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Owner register (IF/LS) plus latched wen/addr/wdata/wlen.
- IDLE: arbitrate combinationally.
  - Winner = LS if ls_req_valid, unless the IF starvation count equals STARVE_LIMIT (when nonzero) and if_req_valid is high; then winner = IF.
  - Assert ready only to the winner. On the handshake, latch the fields (IF forces wen=0, wdata=0, wlen=0), set owner, go to ISSUE.
- ISSUE: mem_req_valid=1 with the latched fields held stable. On mem_req_ready go to WAIT. Both requester readies stay 0.
- WAIT: mem_resp_valid routes to the owner: owner_resp_valid=1 in the same cycle. Data is mem_resp_rdata, except ls_resp_rdata=0 when the owner's wen=1. Then go to IDLE.
- Any mem_resp_valid in IDLE or ISSUE is ignored and never forwarded.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, response earliest at N+2. A new request can be accepted the cycle after the response.
- No request accepted outside IDLE. Readies are 0 in ISSUE and WAIT.
- Starvation counter (4 bits):
  - Increments when LS wins while if_req_valid=1.
  - Clears when IF wins or when if_req_valid=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Reset: state IDLE, owner IF, counter 0, latched fields 0. All outputs 0. A transaction in flight is dropped and no response is delivered; the downstream side is reset by the same rst.
- mem_req_* outputs are 0 whenever mem_req_valid=0.

Optional Feature:
MEM_ARB_RESP_REG_EN: when defined, the response path is registered. owner_resp_valid and rdata appear one cycle after mem_resp_valid, the FSM leaves WAIT through an extra RESP state, and minimum latency becomes N+3. When undefined, the response path is combinational as described above.

Test Plan:
1. IF only: addr 0x80000000; mem_req_ready=1 at N+1; mem_resp_valid with 0x00000413 at N+2 -> if_req_ready=1 at N, mem_req_addr=0x80000000, wen=0 at N+1, if_resp_valid=1 with 0x00000413 at N+2, ls_resp_valid=0 throughout.
2. IF and LS load (addr 0x80001000) valid together -> ls_req_ready=1 and if_req_ready=0; LS completes first; IF is accepted in the first IDLE cycle after the LS response.
3. LS store addr 0x80002000, wdata 0xDEADBEEF, wlen 4; mem_req_ready low 3 cycles -> mem_req fields stable for all 4 ISSUE cycles; ls_resp_valid=1 with rdata 0 on ack.
4. STARVE_LIMIT=4, LS and IF continuously valid -> grant order LS, LS, LS, LS, IF, LS, ...; with STARVE_LIMIT=0, IF is never granted.
5. rst asserted in WAIT, then mem_resp_valid pulsed -> no resp pulse to either requester; all outputs 0 the cycle after rst; the next IF request is served normally.
6. mem_resp_valid pulsed in IDLE and in ISSUE -> no if/ls resp pulse and the FSM state is unchanged.
